// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg : constants shared by the serial operand transmitter/receiver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// ---------------------------------------------------------------------------
// serial_fa_cell : combinational 1-bit full adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_rx.sv
// ---------------------------------------------------------------------------
// serial_add_rx : bit-serial add/subtract receiver with parallel result output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_add_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             sub,
  output logic [WIDTH:0]   sum_out,
  output logic             done,
  output logic             busy,
  output logic             frame_err
);

  localparam int c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [0:0]         r_state;
  logic               r_mode;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH:0]     r_sum;
  logic               r_done;
  logic               r_err;

  logic w_start;
  logic w_mode;
  logic w_cin;
  logic w_bb;
  logic w_s;
  logic w_cout;

  // On the sof beat the mode and carry-in come straight from sub so bit 0
  // is processed on the same edge that opens the frame.
  assign w_start = bit_valid & sof;
  assign w_mode  = w_start ? sub : r_mode;
  assign w_cin   = w_start ? sub : r_carry;
  assign w_bb    = b_bit ^ w_mode;

  serial_fa_cell u_fa (
    .a    (a_bit),
    .b    (w_bb),
    .cin  (w_cin),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bit_valid) begin
        if (sof) begin
          r_err   <= (r_state == ST_RECV);
          r_mode  <= sub;
          r_carry <= w_cout;
          r_cnt   <= c_one;
          r_sr    <= {w_s, r_sr[WIDTH-1:1]};
          r_state <= ST_RECV;
        end else if (r_state == ST_RECV) begin
          r_carry <= w_cout;
          r_sr    <= {w_s, r_sr[WIDTH-1:1]};
          if (r_cnt == c_last) begin
            r_sum   <= {w_cout, w_s, r_sr[WIDTH-1:1]};
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign sum_out   = r_sum;
  assign done      = r_done;
  assign busy      = (r_state == ST_RECV);
  assign frame_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_add_rx : scoreboard bench for serial_add_rx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_rx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sof = 1'b0;
  logic             bit_valid = 1'b0;
  logic             a_bit = 1'b0;
  logic             b_bit = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH:0]   sum_out;
  logic             done;
  logic             busy;
  logic             frame_err;

  serial_add_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .sub       (sub),
    .sum_out   (sum_out),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] sum;
    int             due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  int   last_done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [WIDTH:0] ref_result(input int a, input int b, input logic s);
    int r;
    if (s) begin
      r = ((a - b) & ((1 << WIDTH) - 1)) | ((a >= b) ? (1 << WIDTH) : 0);
    end else begin
      r = a + b;
    end
    return r[WIDTH:0];
  endfunction

  // Monitor: sample 1 ns after each rising edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (frame_err) err_seen++;
    if (done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum_out", 32'(sum_out), 32'(e.sum));
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("busy_on_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic beat(input logic a, input logic b, input logic s, input logic m);
    @(negedge clk);
    bit_valid = 1'b1;
    a_bit     = a;
    b_bit     = b;
    sof       = s;
    sub       = m;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      sof       = 1'($urandom);
      sub       = 1'($urandom);
    end
  endtask

  // Sends a full frame; gap_mask bit i inserts gap_len idle cycles after bit i.
  task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic m, input logic [WIDTH-1:0] gap_mask, input int gap_len);
    for (int i = 0; i < WIDTH; i++) begin
      beat(a[i], b[i], (i == 0), m);
      if (i == WIDTH - 1) begin
        exp_t e;
        e.sum = ref_result(int'(a), int'(b), m);
        e.due = cyc + 1;
        exp_q.push_back(e);
      end else if (gap_mask[i]) begin
        idle(gap_len);
      end
    end
  endtask

  task automatic drain(input int n);
    idle(n);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_err_count", 32'(err_seen), 32'(err_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1;
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_sum", 32'(sum_out), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);

    // Directed additions and subtractions.
    send_frame(8'h2A, 8'h55, 1'b0, 8'h00, 0); idle(2);
    send_frame(8'hFF, 8'h01, 1'b0, 8'h00, 0); idle(2);
    send_frame(8'h55, 8'h2A, 1'b1, 8'h00, 0); idle(2);
    send_frame(8'h01, 8'h02, 1'b1, 8'h00, 0); idle(2);
    // Gaps after bits 2 and 5.
    send_frame(8'h2A, 8'h55, 1'b0, 8'h24, 2);
    drain(3);

    // Abort at bit 4, restart on the same beat.
    for (int i = 0; i < 4; i++) beat(1'b1, (i == 0), (i == 0), 1'b0);
    err_exp++;
    send_frame(8'h0F, 8'h01, 1'b0, 8'h00, 0);
    drain(3);
    chk("sum_after_abort", 32'(sum_out), 32'h010);

    // Reset mid-frame discards the frame and clears the result.
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, (i == 0), 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("sum_after_rst", 32'(sum_out), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);

    // Stray beat in IDLE.
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    err_exp++;
    idle(1);
    #1;
    chk("busy_after_stray", 32'(busy), 32'd0);
    drain(3);
    chk("sum_after_stray", 32'(sum_out), 32'd0);

    // Back-to-back frames: second sof lands on the done cycle.
    send_frame(8'h80, 8'h80, 1'b0, 8'h00, 0);
    d1 = cyc + 1;
    send_frame(8'h03, 8'h04, 1'b0, 8'h00, 0);
    drain(3);
    chk("b2b_spacing", 32'(last_done_cyc - d1), 32'd8);

    // Randomised frames, random gaps and occasional back-to-back.
    for (int k = 0; k < 40; k++) begin
      logic [WIDTH-1:0] a, b, gm;
      logic m;
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      m  = 1'($urandom);
      gm = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : '0;
      send_frame(a, b, m, gm, $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
